i2c_target_model: RTL and testbench
===================================

# i2c_target_model

Synthesizable I2C target (slave) that sits directly downstream of the I2C controller on the shared `sda`/`scl` bus. It gives the controller a real addressed device to talk to: a 16-byte register file reached through a register pointer. It oversamples the open-drain bus on the APB clock, decodes START/STOP, address, and data bytes, and drives ACK and read data back onto `sda`. A status/write-strobe side port lets the bench check every byte it accepts.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit bus address the block responds to.
- `MEM_DEPTH`, default 16: register file depth. Power of two; pointer width is log2(MEM_DEPTH).
- `RESET_FILL`, default 8'h00: value of every register after reset.

Ports:
- `pclk_i` in 1: sampling clock; must be ≥4× the SCL frequency.
- `preset_ni` in 1: reset; **one clock; reset is asynchronous and active-low**.
- `scl_i` in 1: resolved bus SCL; asynchronous to `pclk_i`.
- `sda_i` in 1: resolved bus SDA; asynchronous to `pclk_i`.
- `sda_oe_o` out 1: 1 pulls SDA low. The bus wrapper drives `sda = sda_oe_o ? 1'b0 : 1'bz`.
- `busy_o` out 1: high from an address-matched START to the next STOP.
- `wr_valid_o` out 1: single-cycle pulse when a data byte is written to memory.
- `wr_addr_o` out log2(MEM_DEPTH): address of that write.
- `wr_data_o` out 8: data of that write.
- `ptr_o` out log2(MEM_DEPTH): current register pointer.

## Operation
- Synchronize `scl_i` and `sda_i` with 2-flop synchronizers, then add one history flop for edge detect. "rise" and "fall" refer to the synchronized SCL.
- START: SDA falls while SCL is high. From any state, go to ADDR and clear the bit counter. A repeated START behaves identically.
- STOP: SDA rises while SCL is high. From any state, go to IDLE, release SDA, and drop `busy_o`.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on rise.
    - Address matches `TARGET_ADDR`: go to ADDR_ACK and latch the R/W bit.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: drive ACK.
    - After a write address: go to PTR.
    - After a read address: go to RD_BYTE; load the shifter with mem[ptr].
  - PTR: the first write byte sets the pointer to `byte[log2(MEM_DEPTH)-1:0]`; upper bits are ignored. Then go to WR_ACK.
  - WR_BYTE: on the 8th bit, write mem[ptr], pulse `wr_valid_o`, increment the pointer. Then go to WR_ACK.
  - WR_ACK: ACK, then go to WR_BYTE.
  - RD_BYTE: drive the shifter MSB-first. After the 8th bit, go to RD_ACK and increment the pointer.
  - RD_ACK: sample the controller's bit on rise.
    - ACK (0): reload the shifter with mem[ptr] and go to RD_BYTE.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer wraps modulo `MEM_DEPTH` on both read and write.
- The block never stretches the clock.

## Timing
- Reset values: `sda_oe_o`=0, `busy_o`=0, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `ptr_o`=0, state IDLE, all memory = `RESET_FILL`.
- Input latency: 3 `pclk_i` cycles from a bus edge to the internal edge strobe.
- `sda_oe_o` changes only on the cycle after a fall strobe, so SDA is stable while SCL is high.
  - ACK is asserted after the fall that ends the 8th bit and released after the next fall.
- `wr_valid_o` pulses on the cycle after the 8th-bit rise strobe. `wr_addr_o` and `wr_data_o` hold until the next write.
- A START or STOP seen in the same cycle as a rise strobe takes priority.
- Asynchronous reset mid-transfer releases SDA immediately (combinationally via the reset flops) and returns to IDLE. The block then ignores the bus until the next START.

## Structure
- Package `i2c_pkg`: `i2c_tgt_state_e` enum, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, R/W bit encoding (1 = read).
- Sub-module `i2c_bus_sync`: 2-flop synchronizers plus edge/START/STOP detect, reusable by the controller side.
- Memory is an inferred flop array, with no byte enables.

## Test plan
- Write: START, 0xA0, 0x03, 0x5A, STOP. Required: three ACKs; one `wr_valid_o` pulse with addr 3, data 0x5A; `ptr_o`=4.
- Read with repeated START: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (controller ACK then NACK), STOP. Required: bytes 0x5A then mem[4]=0x00; `ptr_o`=5.
- Address mismatch: START, 0xA2, one more byte, STOP. Required: SDA never pulled low; no `wr_valid_o`; `busy_o` stays 0.
- Wrap: pointer 0x0F, write 0x11 and 0x22. Required: mem[15]=0x11, mem[0]=0x22, `ptr_o`=1.
- Reset mid-transfer: assert `preset_ni` while the target drives ACK. Required: `sda_oe_o`=0 immediately. A subsequent clean write transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared I2C bus constants and target FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    TGT_IDLE     = 4'd0,
    TGT_ADDR     = 4'd1,
    TGT_ADDR_ACK = 4'd2,
    TGT_PTR      = 4'd3,
    TGT_WR_BYTE  = 4'd4,
    TGT_WR_ACK   = 4'd5,
    TGT_RD_BYTE  = 4'd6,
    TGT_RD_ACK   = 4'd7,
    TGT_IGNORE   = 4'd8
  } i2c_tgt_state_e;

  localparam logic       I2C_ACK           = 1'b0;
  localparam logic       I2C_NACK          = 1'b1;
  localparam logic       I2C_RW_READ       = 1'b1;
  localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module  : i2c_bus_sync
// Brief   : 2-flop SCL/SDA synchronizers with SCL edge and START/STOP detect.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;
  logic       w_scl;
  logic       w_sda;

  // Reset to the idle (released) bus level so no false edge appears at reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_hist;
  assign o_scl_fall = ~w_scl & r_scl_hist;
  assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_model.sv
`default_nettype none
// ============================================================================
// Module  : i2c_target_model
// Brief   : I2C target with a pointer-addressed register file and write strobe.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_target_model
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         MEM_DEPTH   = 16,
  parameter logic [7:0] RESET_FILL  = 8'h00
) (
  input  logic                         pclk_i,
  input  logic                         preset_ni,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe_o,
  output logic                         busy_o,
  output logic                         wr_valid_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o,
  output logic [$clog2(MEM_DEPTH)-1:0] ptr_o
);

  localparam int c_ptr_w = $clog2(MEM_DEPTH);

  i2c_tgt_state_e     r_state;
  i2c_tgt_state_e     w_state_nxt;
  logic               w_sda;
  logic               w_rise;
  logic               w_fall;
  logic               w_start;
  logic               w_stop;
  logic               w_byte_end;
  logic               w_addr_hit;
  logic [7:0]         w_byte;
  logic [7:0]         r_shift;
  logic [3:0]         r_cnt;
  logic               r_rw;
  logic               r_rd_bit;
  logic               r_busy;
  logic               r_wr_valid;
  logic [c_ptr_w-1:0] r_wr_addr;
  logic [7:0]         r_wr_data;
  logic [c_ptr_w-1:0] r_ptr;
  logic [7:0]         r_mem [MEM_DEPTH];
  logic               w_sda_oe;

  i2c_bus_sync u_sync (
    .i_clk      (pclk_i),
    .i_rst_n    (preset_ni),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // The fall after the 8th rise is where a byte hands over to its ACK slot.
  assign w_byte_end = w_fall && (r_cnt == I2C_BITS_PER_BYTE);
  assign w_addr_hit = (r_shift[7:1] == TARGET_ADDR);
  assign w_byte     = {r_shift[6:0], w_sda};

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) r_state <= TGT_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = TGT_ADDR;
    end else if (w_stop) begin
      w_state_nxt = TGT_IDLE;
    end else begin
      case (r_state)
        TGT_ADDR:     if (w_byte_end) w_state_nxt = w_addr_hit ? TGT_ADDR_ACK : TGT_IGNORE;
        TGT_ADDR_ACK: if (w_fall) w_state_nxt = (r_rw == I2C_RW_READ) ? TGT_RD_BYTE : TGT_PTR;
        TGT_PTR,
        TGT_WR_BYTE:  if (w_byte_end) w_state_nxt = TGT_WR_ACK;
        TGT_WR_ACK:   if (w_fall) w_state_nxt = TGT_WR_BYTE;
        TGT_RD_BYTE:  if (w_byte_end) w_state_nxt = TGT_RD_ACK;
        TGT_RD_ACK:   if (w_fall) w_state_nxt = (r_rd_bit == I2C_NACK) ? TGT_IGNORE : TGT_RD_BYTE;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_sda_oe = 1'b0;
    case (r_state)
      TGT_ADDR_ACK, TGT_WR_ACK: w_sda_oe = ~I2C_ACK;
      TGT_RD_BYTE:              w_sda_oe = ~r_shift[7];
      default:                  w_sda_oe = 1'b0;
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_shift    <= 8'h00;
      r_cnt      <= 4'd0;
      r_rw       <= 1'b0;
      r_rd_bit   <= I2C_NACK;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_ptr      <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= RESET_FILL;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_cnt <= 4'd0;
      end else if (w_stop) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          TGT_ADDR, TGT_PTR, TGT_WR_BYTE: begin
            if (w_rise) begin
              r_shift <= w_byte;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == I2C_BITS_PER_BYTE - 4'd1) begin
                if (r_state == TGT_PTR) r_ptr <= w_byte[c_ptr_w-1:0];
                if (r_state == TGT_WR_BYTE) begin
                  r_mem[r_ptr] <= w_byte;
                  r_wr_valid   <= 1'b1;
                  r_wr_addr    <= r_ptr;
                  r_wr_data    <= w_byte;
                  r_ptr        <= r_ptr + 1'b1;
                end
              end
            end else if (w_byte_end && r_state == TGT_ADDR && w_addr_hit) begin
              r_rw   <= r_shift[0];
              r_busy <= 1'b1;
            end
          end
          TGT_ADDR_ACK: begin
            if (w_fall) begin
              r_cnt <= 4'd0;
              if (r_rw == I2C_RW_READ) r_shift <= r_mem[r_ptr];
            end
          end
          TGT_WR_ACK: if (w_fall) r_cnt <= 4'd0;
          TGT_RD_BYTE: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_fall) begin
              if (r_cnt == I2C_BITS_PER_BYTE) r_ptr <= r_ptr + 1'b1;
              else                            r_shift <= {r_shift[6:0], 1'b0};
            end
          end
          TGT_RD_ACK: begin
            if (w_rise) begin
              r_rd_bit <= w_sda;
            end else if (w_fall) begin
              r_cnt   <= 4'd0;
              r_shift <= r_mem[r_ptr];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o   = w_sda_oe;
  assign busy_o     = r_busy;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign ptr_o      = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_target_model
// Brief   : Directed bus-level bench for the I2C target register model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_target_model;

  localparam int Q = 8;  // pclk cycles per quarter SCL period

  logic       pclk;
  logic       preset_n;
  logic       scl;
  logic       sda_ctrl;
  logic       sda_bus;
  logic       sda_oe;
  logic       busy;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] ptr;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  bit oe_seen = 0;
  bit busy_seen = 0;

  assign sda_bus = sda_ctrl & ~sda_oe;

  i2c_target_model #(
    .TARGET_ADDR (7'h50),
    .MEM_DEPTH   (16),
    .RESET_FILL  (8'h00)
  ) dut (
    .pclk_i     (pclk),
    .preset_ni  (preset_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .busy_o     (busy),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .ptr_o      (ptr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wr_valid) wr_cnt = wr_cnt + 1;
    if (sda_oe)   oe_seen = 1'b1;
    if (busy)     busy_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge pclk);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b1; scl = 1'b1; wait_q();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_rstart();
    sda_ctrl = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_ctrl = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_ctrl = 1'b1; wait_q();
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    sda_ctrl = b; wait_q();
    scl = 1'b1; wait_q();
    seen = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ctrl_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ctrl_ack, s);
  endtask

  task automatic test_reset();
    preset_n = 1'b0; scl = 1'b1; sda_ctrl = 1'b1;
    repeat (4) @(negedge pclk);
    preset_n = 1'b1;
    repeat (4) @(negedge pclk);
    checks += 6;
    if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_oe: got %b expected 0", sda_oe); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    if (wr_addr !== 4'h0)  begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    if (ptr !== 4'h0)      begin errors++; $display("FAIL reset_ptr: got %h expected 0", ptr); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    wr_cnt = 0;
    bus_start();
    send_byte(8'hA0, a0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
    send_byte(8'h03, a1);
    send_byte(8'h5A, a2);
    bus_stop(); wait_q();
    checks += 8;
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
    if (wr_cnt !== 1)      begin errors++; $display("FAIL write_count: got %0d expected 1", wr_cnt); end
    if (wr_addr !== 4'h3)  begin errors++; $display("FAIL write_addr: got %h expected 3", wr_addr); end
    if (wr_data !== 8'h5A) begin errors++; $display("FAIL write_data: got %h expected 5a", wr_data); end
    if (ptr !== 4'h4)      begin errors++; $display("FAIL write_ptr: got %h expected 4", ptr); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
    if (sda_oe !== 1'b0)   begin errors++; $display("FAIL write_oe_idle: got %b expected 0", sda_oe); end
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL write_pulse_width: got %b expected 0", wr_valid); end
  endtask

  task automatic test_read_rstart();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    wr_cnt = 0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    bus_rstart();
    send_byte(8'hA1, a2);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    bus_stop(); wait_q();
    checks += 5;
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
    if (d0 !== 8'h5A)  begin errors++; $display("FAIL read_byte0: got %h expected 5a", d0); end
    if (d1 !== 8'h00)  begin errors++; $display("FAIL read_byte1: got %h expected 00", d1); end
    if (ptr !== 4'h5)  begin errors++; $display("FAIL read_ptr: got %h expected 5", ptr); end
    if (wr_cnt !== 0)  begin errors++; $display("FAIL read_no_write: got %0d expected 0", wr_cnt); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    wr_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
    bus_start();
    send_byte(8'hA2, a0);
    send_byte(8'h55, a1);
    bus_stop(); wait_q();
    checks += 5;
    if (a0 !== 1'b1)      begin errors++; $display("FAIL mismatch_addr_nack: got %b expected 1", a0); end
    if (a1 !== 1'b1)      begin errors++; $display("FAIL mismatch_data_nack: got %b expected 1", a1); end
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL mismatch_oe: got %b expected 0", oe_seen); end
    if (wr_cnt !== 0)     begin errors++; $display("FAIL mismatch_write: got %0d expected 0", wr_cnt); end
    if (busy_seen !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b expected 0", busy_seen); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3, a4, a5, a6;
    logic [7:0] d0, d1;
    wr_cnt = 0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop(); wait_q();
    checks += 5;
    if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); end
    if (ptr !== 4'h1)      begin errors++; $display("FAIL wrap_ptr: got %h expected 1", ptr); end
    if (wr_cnt !== 2)      begin errors++; $display("FAIL wrap_count: got %0d expected 2", wr_cnt); end
    if (wr_addr !== 4'h0)  begin errors++; $display("FAIL wrap_last_addr: got %h expected 0", wr_addr); end
    if (wr_data !== 8'h22) begin errors++; $display("FAIL wrap_last_data: got %h expected 22", wr_data); end
    bus_start();
    send_byte(8'hA0, a4);
    send_byte(8'h0F, a5);
    bus_rstart();
    send_byte(8'hA1, a6);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    bus_stop(); wait_q();
    checks += 4;
    if ({a4, a5, a6} !== 3'b000) begin errors++; $display("FAIL wrap_read_acks: got %b expected 000", {a4, a5, a6}); end
    if (d0 !== 8'h11) begin errors++; $display("FAIL wrap_mem15: got %h expected 11", d0); end
    if (d1 !== 8'h22) begin errors++; $display("FAIL wrap_mem0: got %h expected 22", d1); end
    if (ptr !== 4'h1) begin errors++; $display("FAIL wrap_read_ptr: got %h expected 1", ptr); end
  endtask

  task automatic test_reset_mid();
    logic s, a0, a1, a2;
    logic [7:0] addr_byte;
    addr_byte = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(addr_byte[i], s);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL midrst_ack_driven: got %b expected 1", sda_oe); end
    #3 preset_n = 1'b0;
    #1;
    checks += 3;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe_release: got %b expected 0", sda_oe); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (ptr !== 4'h0)    begin errors++; $display("FAIL midrst_ptr: got %h expected 0", ptr); end
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    sda_ctrl = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    wr_cnt = 0;
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h07, a1);
    send_byte(8'hC3, a2);
    bus_stop(); wait_q();
    checks += 5;
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL midrst_acks: got %b expected 000", {a0, a1, a2}); end
    if (wr_cnt !== 1)      begin errors++; $display("FAIL midrst_count: got %0d expected 1", wr_cnt); end
    if (wr_addr !== 4'h7)  begin errors++; $display("FAIL midrst_addr: got %h expected 7", wr_addr); end
    if (wr_data !== 8'hC3) begin errors++; $display("FAIL midrst_data: got %h expected c3", wr_data); end
    if (ptr !== 4'h8)      begin errors++; $display("FAIL midrst_ptr_after: got %h expected 8", ptr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rstart();
    test_mismatch();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
